// File: rtl/bombe_pkg.sv
// Shared types and helpers for the bombe rotor stack: FSM encoding,
// default geometry and the modulo-increment / range-clamp functions.
package bombe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADVANCE  = 2'd1,
        ST_ANNOUNCE = 2'd2
    } state_t;

    localparam int DEF_MODULUS = 26;
    localparam int DEF_POS_W   = 5;

    function automatic logic [7:0] mod_inc(input logic [7:0] pos, input int modulus);
        int v;
        v = int'(pos) + 1;
        if (v >= modulus) v = 0;
        return 8'(v);
    endfunction

    function automatic logic [7:0] clamp_pos(input logic [7:0] pos, input int modulus);
        return (int'(pos) >= modulus) ? 8'd0 : pos;
    endfunction

endpackage

// File: rtl/rotor_cell.sv
// One rotor: position and notch registers, synchronous load, enabled
// modulo increment, and a flag telling whether the rotor sits on its notch.
module rotor_cell
    import bombe_pkg::*;
#(
    parameter int MODULUS = DEF_MODULUS,
    parameter int POS_W   = DEF_POS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [POS_W-1:0] i_load_pos,
    input  logic [POS_W-1:0] i_load_notch,
    input  logic             i_en,
    output logic [POS_W-1:0] o_pos,
    output logic [POS_W-1:0] o_pos_nxt,
    output logic             o_at_notch
);

    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_notch;
    logic [POS_W-1:0] w_inc;

    assign w_inc = POS_W'(mod_inc(8'(r_pos), MODULUS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos   <= '0;
            r_notch <= '0;
        end else if (i_load) begin
            r_pos   <= i_load_pos;
            r_notch <= i_load_notch;
        end else if (i_en) begin
            r_pos   <= w_inc;
        end
    end

    // Position never leaves 0..MODULUS-1, so an out-of-range notch can never match.
    assign o_at_notch = (r_pos == r_notch);
    assign o_pos      = r_pos;
    assign o_pos_nxt  = i_en ? w_inc : r_pos;

endmodule

// File: rtl/bombe_rotor_stack.sv
// Odometer-style rotor stack with step handshake and sweep detection.
// Optional macro BOMBE_DOUBLE_STEP_EN adds the Enigma middle-rotor double step.
module bombe_rotor_stack
    import bombe_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int MODULUS    = DEF_MODULUS,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [NUM_ROTORS*POS_W-1:0]   init_pos,
    input  logic [NUM_ROTORS*POS_W-1:0]   notch_pos,
    input  logic                          step_req,
    output logic                          step_ready,
    output logic                          step_done,
    output logic                          sweep_done,
    output logic [NUM_ROTORS*8-1:0]       rotor_out
);

    localparam int W = NUM_ROTORS * POS_W;

    state_t          r_state;
    logic            r_step_ready;
    logic            r_step_done;
    logic            r_sweep_done;
    logic [W-1:0]    r_start;

    logic [NUM_ROTORS-1:0] w_adv;
    logic [NUM_ROTORS-1:0] w_en;
    logic [NUM_ROTORS-1:0] w_notch;
    logic [W-1:0]          w_pos;
    logic [W-1:0]          w_pos_nxt;
    logic [W-1:0]          w_init;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROTORS; gi++) begin : g_rotor
            assign w_init[gi*POS_W +: POS_W] =
                POS_W'(clamp_pos(8'(init_pos[gi*POS_W +: POS_W]), MODULUS));
            assign w_en[gi] = (r_state == ST_ADVANCE) & w_adv[gi];

            rotor_cell #(
                .MODULUS (MODULUS),
                .POS_W   (POS_W)
            ) u_cell (
                .clk          (clk),
                .reset        (reset),
                .i_load       (load),
                .i_load_pos   (w_init[gi*POS_W +: POS_W]),
                .i_load_notch (notch_pos[gi*POS_W +: POS_W]),
                .i_en         (w_en[gi]),
                .o_pos        (w_pos[gi*POS_W +: POS_W]),
                .o_pos_nxt    (w_pos_nxt[gi*POS_W +: POS_W]),
                .o_at_notch   (w_notch[gi])
            );

            assign rotor_out[gi*8 +: 8] = 8'(w_pos[gi*POS_W +: POS_W]);
        end
    endgenerate

    // Carry chain evaluated on the pre-step positions held during ADVANCE.
    always_comb begin
        w_adv    = '0;
        w_adv[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            w_adv[i] = w_adv[i-1] & w_notch[i-1];
`ifdef BOMBE_DOUBLE_STEP_EN
            if ((i < NUM_ROTORS - 1) && w_notch[i]) w_adv[i] = 1'b1;
            if ((i >= 2) && w_notch[i-1])            w_adv[i] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_step_ready <= 1'b1;
            r_step_done  <= 1'b0;
            r_sweep_done <= 1'b0;
            r_start      <= '0;
        end else if (load) begin
            r_state      <= ST_IDLE;
            r_step_ready <= 1'b1;
            r_step_done  <= 1'b0;
            r_sweep_done <= 1'b0;
            r_start      <= w_init;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_step_done  <= 1'b0;
                    r_sweep_done <= 1'b0;
                    if (step_req) begin
                        r_state      <= ST_ADVANCE;
                        r_step_ready <= 1'b0;
                    end
                end
                ST_ADVANCE: begin
                    r_state      <= ST_ANNOUNCE;
                    r_step_done  <= 1'b1;
                    r_sweep_done <= (w_pos_nxt == r_start);
                end
                ST_ANNOUNCE: begin
                    r_state      <= ST_IDLE;
                    r_step_ready <= 1'b1;
                    r_step_done  <= 1'b0;
                    r_sweep_done <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_step_ready <= 1'b1;
                    r_step_done  <= 1'b0;
                    r_sweep_done <= 1'b0;
                end
            endcase
        end
    end

    assign step_ready = r_step_ready;
    assign step_done  = r_step_done;
    assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_bombe_rotor_stack.sv
// Scoreboard bench: a 3x26 stack and a 2x4 stack; expected positions are
// queued when a step is issued and popped by monitors on each step_done.
module tb_bombe_rotor_stack;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_load = 1'b0, a_req = 1'b0;
    logic [14:0] a_init = '0, a_notch = '0;
    logic        a_ready, a_done, a_sweep;
    logic [23:0] a_out;

    logic        b_load = 1'b0, b_req = 1'b0;
    logic [3:0]  b_init = '0, b_notch = '0;
    logic        b_ready, b_done, b_sweep;
    logic [15:0] b_out;

    bombe_rotor_stack #(.NUM_ROTORS(3), .MODULUS(26), .POS_W(5)) dut_a (
        .clk(clk), .reset(reset), .load(a_load), .init_pos(a_init), .notch_pos(a_notch),
        .step_req(a_req), .step_ready(a_ready), .step_done(a_done), .sweep_done(a_sweep),
        .rotor_out(a_out)
    );

    bombe_rotor_stack #(.NUM_ROTORS(2), .MODULUS(4), .POS_W(2)) dut_b (
        .clk(clk), .reset(reset), .load(b_load), .init_pos(b_init), .notch_pos(b_notch),
        .step_req(b_req), .step_ready(b_ready), .step_done(b_done), .sweep_done(b_sweep),
        .rotor_out(b_out)
    );

    int vectors = 0;
    int miscompares = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    logic [24:0] q_a[$];
    logic [16:0] q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] p3(input int r0, input int r1, input int r2);
        return {8'(r2), 8'(r1), 8'(r0)};
    endfunction

    function automatic logic [14:0] f3(input int r0, input int r1, input int r2);
        return {5'(r2), 5'(r1), 5'(r0)};
    endfunction

    function automatic logic [15:0] p2(input int r0, input int r1);
        return {8'(r1), 8'(r0)};
    endfunction

    function automatic logic [3:0] f2(input int r0, input int r1);
        return {2'(r1), 2'(r0)};
    endfunction

    always @(negedge clk) begin : mon_a
        logic [24:0] e;
        if (a_done) begin
            a_done_cnt++;
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected_step_done: rotor_out=%0h sweep=%0b", a_out, a_sweep);
            end else begin
                e = q_a.pop_front();
                check("a_step {sweep,rotor_out}", 32'({a_sweep, a_out}), 32'(e));
            end
        end else if (a_sweep) begin
            vectors++;
            miscompares++;
            $display("FAIL a_sweep_without_done: sweep=1 expected 0");
        end
    end

    always @(negedge clk) begin : mon_b
        logic [16:0] e;
        if (b_done) begin
            b_done_cnt++;
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected_step_done: rotor_out=%0h sweep=%0b", b_out, b_sweep);
            end else begin
                e = q_b.pop_front();
                check("b_step {sweep,rotor_out}", 32'({b_sweep, b_out}), 32'(e));
            end
        end else if (b_sweep) begin
            vectors++;
            miscompares++;
            $display("FAIL b_sweep_without_done: sweep=1 expected 0");
        end
    end

    task automatic wait_ready_a();
        int n = 0;
        while (!a_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL a_ready_timeout: step_ready=0 expected 1");
        end
    endtask

    task automatic wait_ready_b();
        int n = 0;
        while (!b_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!b_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL b_ready_timeout: step_ready=0 expected 1");
        end
    endtask

    task automatic step_a(input logic [23:0] exp_out, input logic exp_sweep);
        q_a.push_back({exp_sweep, exp_out});
        @(negedge clk) a_req = 1'b1;
        @(negedge clk) a_req = 1'b0;
        wait_ready_a();
    endtask

    task automatic step_b(input logic [15:0] exp_out, input logic exp_sweep);
        q_b.push_back({exp_sweep, exp_out});
        @(negedge clk) b_req = 1'b1;
        @(negedge clk) b_req = 1'b0;
        wait_ready_b();
    endtask

    task automatic load_a(input logic [14:0] init, input logic [14:0] notch, input logic [23:0] exp_out);
        @(negedge clk);
        a_load  = 1'b1;
        a_init  = init;
        a_notch = notch;
        @(negedge clk) a_load = 1'b0;
        check("a_load rotor_out", 32'(a_out), 32'(exp_out));
        check("a_load step_ready", 32'(a_ready), 32'd1);
    endtask

    initial begin : main
        int c0;
        int v;
        @(negedge clk);
        check("reset rotor_out", 32'(a_out), 32'd0);
        check("reset step_ready", 32'(a_ready), 32'd1);
        check("reset step_done", 32'(a_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset while a step is in ADVANCE
        load_a(f3(5, 6, 7), f3(0, 0, 0), p3(5, 6, 7));
        c0 = a_done_cnt;
        @(negedge clk) a_req = 1'b1;
        @(negedge clk) a_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midadv reset rotor_out", 32'(a_out), 32'd0);
        check("midadv reset step_ready", 32'(a_ready), 32'd1);
        check("midadv reset step_done", 32'(a_done), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midadv no step_done", 32'(a_done_cnt), 32'(c0));
        check("midadv rotor_out after", 32'(a_out), 32'd0);

        // Plain odometer: 26 steps from zero
        load_a(f3(0, 0, 0), f3(25, 25, 25), p3(0, 0, 0));
        for (int k = 1; k <= 26; k++) step_a(p3(k % 26, k / 26, 0), 1'b0);

        // Carry through two rotors
        load_a(f3(24, 3, 7), f3(25, 4, 9), p3(24, 3, 7));
        step_a(p3(25, 3, 7), 1'b0);
        step_a(p3(0, 4, 7), 1'b0);
        for (int j = 1; j <= 26; j++) begin
`ifdef BOMBE_DOUBLE_STEP_EN
            step_a(p3(j % 26, (j == 26) ? 6 : 5, 8), 1'b0);
`else
            step_a(p3(j % 26, (j == 26) ? 5 : 4, (j == 26) ? 8 : 7), 1'b0);
`endif
        end

        // Middle rotor sitting on its notch
        load_a(f3(25, 3, 0), f3(25, 4, 9), p3(25, 3, 0));
        step_a(p3(0, 4, 0), 1'b0);
`ifdef BOMBE_DOUBLE_STEP_EN
        step_a(p3(1, 5, 1), 1'b0);
`else
        step_a(p3(1, 4, 0), 1'b0);
`endif

        // Out-of-range init loads 0, out-of-range notch never carries
        load_a(f3(25, 30, 0), f3(31, 7, 0), p3(25, 0, 0));
        step_a(p3(0, 0, 0), 1'b0);

        // Load collides with a request, then cancels an ADVANCE
        load_a(f3(1, 2, 3), f3(0, 0, 0), p3(1, 2, 3));
        c0 = a_done_cnt;
        @(negedge clk);
        a_load = 1'b1;
        a_req  = 1'b1;
        a_init = f3(10, 11, 12);
        @(negedge clk);
        a_load = 1'b0;
        a_req  = 1'b0;
        repeat (4) @(negedge clk);
        check("collide rotor_out", 32'(a_out), 32'(p3(10, 11, 12)));
        check("collide no step_done", 32'(a_done_cnt), 32'(c0));
        check("collide step_ready", 32'(a_ready), 32'd1);
        @(negedge clk) a_req = 1'b1;
        @(negedge clk);
        a_req  = 1'b0;
        a_load = 1'b1;
        a_init = f3(20, 21, 22);
        @(negedge clk) a_load = 1'b0;
        repeat (4) @(negedge clk);
        check("cancel rotor_out", 32'(a_out), 32'(p3(20, 21, 22)));
        check("cancel no step_done", 32'(a_done_cnt), 32'(c0));
        step_a(p3(21, 21, 22), 1'b0);

        // Small stack: full sweep of 16 steps
        @(negedge clk);
        b_load  = 1'b1;
        b_init  = f2(1, 2);
        b_notch = f2(3, 3);
        @(negedge clk) b_load = 1'b0;
        check("b_load rotor_out", 32'(b_out), 32'(p2(1, 2)));
        for (int k = 1; k <= 16; k++) begin
            v = (9 + k) % 16;
            step_b(p2(v % 4, v / 4), k == 16);
        end
        check("b_done count", 32'(b_done_cnt), 32'd16);

        repeat (4) @(negedge clk);
        check("a_queue drained", 32'(q_a.size()), 32'd0);
        check("b_queue drained", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bombe_rotor_stack.md
Name: bombe_rotor_stack

Overview:
- Parametrised, clocked stack of NUM_ROTORS rotors for the bombe search engine. Each rotor position runs 0..MODULUS-1.
- Rotor 0 advances once per accepted step request. Higher rotors advance by notch carry, odometer style.
- Signals a completed sweep when the stack returns to its loaded start positions. Drives the permutation datapath and the bombe stop logic.

Parameters:
- NUM_ROTORS, 3, number of rotors in the stack (2..8)
- MODULUS, 26, positions per rotor
- POS_W, 5, position field width; must satisfy 2**POS_W >= MODULUS

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  synchronous load of start positions and notches
- init_pos  in  NUM_ROTORS*POS_W  start positions; rotor i at bits [i*POS_W +: POS_W]
- notch_pos  in  NUM_ROTORS*POS_W  notch (turnover) positions, same packing
- step_req  in  1  request one step
- step_ready  out  1  high when a request will be accepted
- step_done  out  1  one-cycle pulse after the positions have updated
- sweep_done  out  1  one-cycle pulse, coincident with step_done, when positions equal the start positions
- rotor_out  out  NUM_ROTORS*8  positions zero-extended to 8 bits, rotor i at [i*8 +: 8]

Behaviour:
- Reset (async):
  - positions, start register and notch register all 0
  - FSM = IDLE
  - step_ready=1, step_done=0, sweep_done=0, rotor_out=0
- FSM states and transitions:
  - IDLE: step_ready=1. step_req=1 -> ADVANCE.
  - ADVANCE: step_ready=0. Positions update at the closing edge. Next state is ANNOUNCE.
  - ANNOUNCE: step_done=1; sweep_done=1 if the new positions equal the start register. step_ready=0. Next state is IDLE.
- Timing:
  - Latency: request sampled at edge N, positions visible after edge N+1, step_done high in the cycle after edge N+1.
  - Throughput: one step per 3 cycles.
  - step_req held high steps again on each return to IDLE.
- Stepping rule:
  - Rotor 0 always advances.
  - Rotor i (i>0) advances iff rotor i-1 advances this step and rotor i-1 is at notch_pos[i-1] before the step.
  - Increment is modulo MODULUS: MODULUS-1 -> 0.
  - The top rotor carries nowhere; the whole stack wraps silently.
- Load:
  - load has priority over step_req and over any state.
  - Captures init_pos into both the positions and the start register, and captures notch_pos.
  - Forces IDLE, with step_done=0 and sweep_done=0.
  - A load during ADVANCE cancels that step; a load during ANNOUNCE suppresses its pulses.
- Out-of-range fields:
  - An init_pos field >= MODULUS loads as 0.
  - A notch_pos field >= MODULUS never matches, so that rotor never carries.
- Simultaneous events:
  - load and step_req together: load wins and the request is dropped.
  - reset overrides everything, asynchronously.
- Sweep period: without the optional feature, sweep_done fires first after MODULUS**NUM_ROTORS steps, provided every notch is in range.

Optional Feature:
- Macro: BOMBE_DOUBLE_STEP_EN
- Defined (Enigma double-step anomaly): rotor i, for 0<i<NUM_ROTORS-1, additionally advances, together with rotor i+1, whenever rotor i sits at its own notch before the step. This applies even without a carry from rotor i-1. Rotor 0 and the top rotor are unchanged. The sweep period shortens accordingly.
- Not defined: pure odometer carry as above.

Decomposition:
- Package bombe_pkg:
  - FSM state encodings (IDLE, ADVANCE, ANNOUNCE)
  - default MODULUS=26 and POS_W=5
  - function mod_inc(pos, modulus)
  - function clamp_pos(pos, modulus)
- Sub-module rotor_cell: one position register with load, enable, modulo increment, and an at_notch output. Instantiate NUM_ROTORS times via generate.
- The stack-level FSM and carry chain stay in bombe_rotor_stack.

Test Plan:
- Reset mid-ADVANCE (assert reset one cycle after step_req) -> rotor_out=0, step_ready=1, no step_done.
- Load init=(0,0,0), notch=(25,25,25); 26 steps -> rotor0 returns to 0 and rotor1=1 on the 26th step_done; sweep_done stays 0.
- Load init=(24,3,7), notch=(25,4,9); 2 steps -> (25,3,7) then (0,4,7). Third batch of 26 steps takes rotor1 from 4 to 5 and rotor2 from 7 to 8.
- NUM_ROTORS=2, MODULUS=4, all notches 3, init (1,2) -> sweep_done exactly once, on step 16, coincident with step_done.
- Load asserted in the same cycle as step_req, and again during ADVANCE -> positions = new init_pos, no step_done pulse, request dropped.
- BOMBE_DOUBLE_STEP_EN, notch=(25,4,9), init=(25,3,0): step -> (0,4,0); step -> (1,5,1), double step. Without the macro the second step gives (1,4,0).
